vga_write_arbiter: RTL and testbench

VGA_WRITE_ARBITER -- requirements
Module: vga_write_arbiter

---
 rtl/vga_write_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_vga_write_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter
//   Shares one VGA adapter write port between a grid renderer (G) and a
//   score renderer (S). A requester is granted the port for a whole shape.
//   The grant ends on an acked pixel flagged "last", or after TIMEOUT idle
//   granted cycles. Contention in IDLE is resolved round-robin.
//
// Ports
//   clock_i, reset_i           single clock, synchronous active-high reset
//   freeze_i                   blocks new grants (an active grant continues)
//   reqG_i/reqS_i              pixel request per renderer
//   lastG_i/lastS_i            current pixel is the last of its shape
//   xG_i/yG_i/colourG_i        G pixel data (8/7/3 bits)
//   xS_i/yS_i/colourS_i        S pixel data (8/7/3 bits)
//   grantG_o/grantS_o          registered ownership of the write port
//   ackG_o/ackS_o              combinational pixel accept
//   x_o/y_o/colour_o/plot_o    registered VGA write port (one cycle after ack)
//   pixelCount_o               pixels accepted in current grant (saturating)
//   timeoutG_o/timeoutS_o      sticky timeout flags, cleared by reset only
//   busy_o                     a grant is active
module vga_write_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        freeze_i,
  input  logic        reqG_i,
  input  logic        reqS_i,
  input  logic        lastG_i,
  input  logic        lastS_i,
  input  logic [7:0]  xG_i,
  input  logic [7:0]  xS_i,
  input  logic [6:0]  yG_i,
  input  logic [6:0]  yS_i,
  input  logic [2:0]  colourG_i,
  input  logic [2:0]  colourS_i,
  output logic        grantG_o,
  output logic        grantS_o,
  output logic        ackG_o,
  output logic        ackS_o,
  output logic [7:0]  x_o,
  output logic [6:0]  y_o,
  output logic [2:0]  colour_o,
  output logic        plot_o,
  output logic [14:0] pixelCount_o,
  output logic        timeoutG_o,
  output logic        timeoutS_o,
  output logic        busy_o
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_G = 2'd1,
    GRANT_S = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                sLast_q, sLast_d;   // 1: S was served most recently
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [14:0]         cnt_q, cnt_d;
  logic                toG_q, toG_d, toS_q, toS_d;
  logic [7:0]          x_q, x_d;
  logic [6:0]          y_q, y_d;
  logic [2:0]          colour_q, colour_d;
  logic                plot_q, plot_d;

  function automatic logic [14:0] sat_inc(input logic [14:0] v);
    return (v == 15'h7FFF) ? v : v + 15'd1;
  endfunction

  assign grantG_o     = (state_q == GRANT_G);
  assign grantS_o     = (state_q == GRANT_S);
  assign ackG_o       = grantG_o & reqG_i;
  assign ackS_o       = grantS_o & reqS_i;
  assign busy_o       = grantG_o | grantS_o;
  assign x_o          = x_q;
  assign y_o          = y_q;
  assign colour_o     = colour_q;
  assign plot_o       = plot_q;
  assign pixelCount_o = cnt_q;
  assign timeoutG_o   = toG_q;
  assign timeoutS_o   = toS_q;

  always_comb begin
    state_d  = state_q;
    sLast_d  = sLast_q;
    idle_d   = idle_q;
    cnt_d    = cnt_q;
    toG_d    = toG_q;
    toS_d    = toS_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!freeze_i) begin
          // G wins a tie only when S held the previous grant
          if (reqG_i && (!reqS_i || sLast_q)) begin
            state_d = GRANT_G;
            idle_d  = '0;
            cnt_d   = '0;
          end else if (reqS_i) begin
            state_d = GRANT_S;
            idle_d  = '0;
            cnt_d   = '0;
          end
        end
      end
      GRANT_G: begin
        if (ackG_o) begin
          x_d      = xG_i;
          y_d      = yG_i;
          colour_d = colourG_i;
          plot_d   = 1'b1;
          cnt_d    = sat_inc(cnt_q);
          idle_d   = '0;
          if (lastG_i) begin
            state_d = IDLE;
            sLast_d = 1'b0;
          end
        end else if (idle_q == IDLE_W'(TIMEOUT)) begin
          state_d = IDLE;
          sLast_d = 1'b0;
          toG_d   = 1'b1;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      GRANT_S: begin
        if (ackS_o) begin
          x_d      = xS_i;
          y_d      = yS_i;
          colour_d = colourS_i;
          plot_d   = 1'b1;
          cnt_d    = sat_inc(cnt_q);
          idle_d   = '0;
          if (lastS_i) begin
            state_d = IDLE;
            sLast_d = 1'b1;
          end
        end else if (idle_q == IDLE_W'(TIMEOUT)) begin
          state_d = IDLE;
          sLast_d = 1'b1;
          toS_d   = 1'b1;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      sLast_q  <= 1'b1;
      idle_q   <= '0;
      cnt_q    <= '0;
      toG_q    <= 1'b0;
      toS_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sLast_q  <= sLast_d;
      idle_q   <= idle_d;
      cnt_q    <= cnt_d;
      toG_q    <= toG_d;
      toS_q    <= toS_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
    end
  end

endmodule

// File: tb/tb_vga_write_arbiter.sv
module tb_vga_write_arbiter;

  logic        clk = 1'b0;
  logic        rst, frz, rG, rS, lG, lS;
  logic [7:0]  xG, xS;
  logic [6:0]  yG, yS;
  logic [2:0]  cG, cS;
  logic        gG, gS, aG, aS, plot, toG, toS, busy;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  col;
  logic [14:0] cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vga_write_arbiter #(.TIMEOUT(16)) dut (
    .clock_i(clk), .reset_i(rst), .freeze_i(frz),
    .reqG_i(rG), .reqS_i(rS), .lastG_i(lG), .lastS_i(lS),
    .xG_i(xG), .xS_i(xS), .yG_i(yG), .yS_i(yS),
    .colourG_i(cG), .colourS_i(cS),
    .grantG_o(gG), .grantS_o(gS), .ackG_o(aG), .ackS_o(aS),
    .x_o(x), .y_o(y), .colour_o(col), .plot_o(plot),
    .pixelCount_o(cnt), .timeoutG_o(toG), .timeoutS_o(toS), .busy_o(busy)
  );

  typedef struct {
    logic rst, frz, rG, rS, lG, lS;
    logic [7:0] xG; logic [6:0] yG; logic [2:0] cG;
    logic [7:0] xS; logic [6:0] yS; logic [2:0] cS;
    logic aG, aS, gG, gS, plot;
    logic [7:0] x; logic [6:0] y; logic [2:0] c;
    int cnt;
    logic toG, toS;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; frz = v.frz; rG = v.rG; rS = v.rS; lG = v.lG; lS = v.lS;
    xG = v.xG; yG = v.yG; cG = v.cG; xS = v.xS; yS = v.yS; cS = v.cS;
  endtask

  initial begin
    rst = 1; frz = 0; rG = 0; rS = 0; lG = 0; lS = 0;
    xG = 0; yG = 0; cG = 0; xS = 0; yS = 0; cS = 0;

    // rst frz rG rS lG lS  xG yG cG  xS yS cS  aG aS gG gS plot  x y c  cnt toG toS
    tbl.push_back('{1,0,0,0,0,0,   0,  0,0,    0,  0,0, 0,0, 0,0,0,   0,  0,0, 0,0,0});
    tbl.push_back('{0,0,1,1,0,0,  10, 20,1,   30, 40,2, 0,0, 1,0,0,   0,  0,0, 0,0,0});
    tbl.push_back('{0,0,1,1,0,0,  11, 21,2,   30, 40,2, 1,0, 1,0,1,  11, 21,2, 1,0,0});
    tbl.push_back('{0,0,1,1,0,0,  12, 22,3,   30, 40,2, 1,0, 1,0,1,  12, 22,3, 2,0,0});
    tbl.push_back('{0,0,1,1,1,0,  13, 23,4,   30, 40,2, 1,0, 0,0,1,  13, 23,4, 3,0,0});
    tbl.push_back('{0,0,1,1,0,0,  14, 24,5,   30, 40,2, 0,0, 0,1,0,  13, 23,4, 0,0,0});
    tbl.push_back('{0,0,1,1,0,0,  14, 24,5,   30, 40,2, 0,1, 0,1,1,  30, 40,2, 1,0,0});
    tbl.push_back('{0,0,1,1,0,1,  14, 24,5,  159,119,7, 0,1, 0,0,1, 159,119,7, 2,0,0});
    tbl.push_back('{0,0,1,1,0,0,  14, 24,5,   30, 40,2, 0,0, 1,0,0, 159,119,7, 0,0,0});
    tbl.push_back('{0,0,1,0,1,0,   1,  2,3,    0,  0,0, 1,0, 0,0,1,   1,  2,3, 1,0,0});
    tbl.push_back('{0,0,1,0,0,0,   1,  2,3,    0,  0,0, 0,0, 1,0,0,   1,  2,3, 0,0,0});
    tbl.push_back('{0,0,1,0,1,0,   4,  5,6,    0,  0,0, 1,0, 0,0,1,   4,  5,6, 1,0,0});
    tbl.push_back('{0,0,1,0,0,0,   4,  5,6,    0,  0,0, 0,0, 1,0,0,   4,  5,6, 0,0,0});
    tbl.push_back('{0,0,1,0,0,0,   7,  8,1,    0,  0,0, 1,0, 1,0,1,   7,  8,1, 1,0,0});
    tbl.push_back('{1,0,1,0,0,0,   9,  9,2,    0,  0,0, 1,0, 0,0,0,   0,  0,0, 0,0,0});
    tbl.push_back('{0,0,1,0,0,0,   3,  3,3,    0,  0,0, 0,0, 1,0,0,   0,  0,0, 0,0,0});
    tbl.push_back('{0,0,1,0,1,0,   5,  6,7,    0,  0,0, 1,0, 0,0,1,   5,  6,7, 1,0,0});
    tbl.push_back('{0,0,0,0,1,1,   0,  0,0,    0,  0,0, 0,0, 0,0,0,   5,  6,7, 1,0,0});
    tbl.push_back('{0,0,0,1,0,0,   0,  0,0,    0,  0,0, 0,0, 0,1,0,   5,  6,7, 0,0,0});
    tbl.push_back('{0,1,0,1,0,0,   0,  0,0,    2,  3,4, 0,1, 0,1,1,   2,  3,4, 1,0,0});
    tbl.push_back('{0,1,1,1,0,1,   9,  9,1,    6,  7,5, 0,1, 0,0,1,   6,  7,5, 2,0,0});
    tbl.push_back('{0,1,1,1,0,0,   9,  9,1,    6,  7,5, 0,0, 0,0,0,   6,  7,5, 2,0,0});

    step();
    step();

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("row%0d ackG", i), aG, tbl[i].aG);
      chk($sformatf("row%0d ackS", i), aS, tbl[i].aS);
      step();
      chk($sformatf("row%0d grantG", i), gG, tbl[i].gG);
      chk($sformatf("row%0d grantS", i), gS, tbl[i].gS);
      chk($sformatf("row%0d busy", i), busy, tbl[i].gG | tbl[i].gS);
      chk($sformatf("row%0d plot", i), plot, tbl[i].plot);
      chk($sformatf("row%0d x", i), x, tbl[i].x);
      chk($sformatf("row%0d y", i), y, tbl[i].y);
      chk($sformatf("row%0d colour", i), col, tbl[i].c);
      chk($sformatf("row%0d pixelCount", i), cnt, tbl[i].cnt);
      chk($sformatf("row%0d timeoutG", i), toG, tbl[i].toG);
      chk($sformatf("row%0d timeoutS", i), toS, tbl[i].toS);
    end

    // Freeze holds off a pending S request; releasing it grants next edge
    frz = 1; rG = 0; rS = 1; lG = 0; lS = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("frozen grantS c%0d", i), gS, 1'b0);
    end
    frz = 0;
    step();
    chk("unfrozen grantS", gS, 1'b1);
    lS = 1;
    step();
    chk("S shape end", gS, 1'b0);

    // Timeout on G: 16 idle granted cycles, revoked on the 17th edge
    rst = 1; rS = 0; lS = 0;
    step();
    rst = 0; rG = 1;
    step();
    chk("to grant entry", gG, 1'b1);
    rG = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("to hold c%0d", i), gG, 1'b1);
    end
    step();
    chk("to revoked grantG", gG, 1'b0);
    chk("to flag", toG, 1'b1);
    chk("to flagS", toS, 1'b0);
    rG = 1;
    step();
    chk("to regrant", gG, 1'b1);
    chk("to sticky1", toG, 1'b1);
    lG = 1;
    step();
    chk("to shape end", gG, 1'b0);
    chk("to sticky2", toG, 1'b1);
    chk("to count", cnt, 15'd1);

    // pixelCount saturation over a long shape
    lG = 0;
    step();
    chk("sat grant", gG, 1'b1);
    for (int i = 0; i < 32770; i++) step();
    chk("sat pixelCount", cnt, 15'd32767);
    chk("sat still granted", gG, 1'b1);

    rst = 1;
    step();
    rst = 0; rG = 0;
    #1;
    chk("post-reset ackG", aG, 1'b0);
    chk("post-reset timeoutG", toG, 1'b0);
    chk("post-reset pixelCount", cnt, 15'd0);
    chk("post-reset grantG", gG, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
